fifo_sync_circular: RTL
=======================

# fifo_sync_circular

Single-clock circular FIFO: the same-clock-domain successor of the dual-clock FIFO, for producer/consumer pairs sharing one clock. It adds a fill-level output, programmable almost-full and almost-empty thresholds, sticky overflow and underflow error flags, and a synchronous flush. First-word-fall-through read mode is a compile-time option. It sits between in-domain datapath stages such as UART RX/TX buffering and DMA staging, with no synchronizers.

## Interface
- DEPTH, 16, number of entries; power of two, at least 2
- WIDTH, 8, data word width in bits
- AFULL_LEVEL, 14, almost_full_out asserts when level ≥ this value; range 1..DEPTH
- AEMPTY_LEVEL, 2, almost_empty_out asserts when level ≤ this value; range 0..DEPTH-1
- PTR_WIDTH (derived), $clog2(DEPTH)+1, pointer width including the wrap bit
- clk_in  input  1  the only clock; all logic on the rising edge
- nrst_in  input  1  reset, asynchronous and active-low
- clear_in  input  1  synchronous flush
- write_in  input  1  write request
- data_write_in  input  WIDTH  write data
- read_in  input  1  read request
- data_read_out  output  WIDTH  read data
- full_out  output  1  level == DEPTH
- empty_out  output  1  level == 0
- almost_full_out  output  1  level ≥ AFULL_LEVEL
- almost_empty_out  output  1  level ≤ AEMPTY_LEVEL
- level_out  output  PTR_WIDTH  current occupancy, 0..DEPTH
- overflow_out  output  1  sticky; set by a rejected write
- underflow_out  output  1  sticky; set by a rejected read

## Operation
- Storage is a register array, DEPTH×WIDTH, and is not reset.
- Binary pointers wptr and rptr are PTR_WIDTH wide. Entries are addressed by the low $clog2(DEPTH) bits; the MSB is the wrap bit.
- level = wptr − rptr, modulo 2^PTR_WIDTH.
- All status flags decode combinationally from the registered pointers and level.
- Write accepted (wr_ok) = write_in & (!full_out | rd_ok).
  - On acceptance: mem[wptr] ← data_write_in, then wptr+1.
- Read accepted (rd_ok) = read_in & !empty_out.
  - On acceptance: rptr+1.
- Simultaneous read and write:
  - When full: both are accepted and level is unchanged. The read frees the slot the write fills.
  - When empty: the write is accepted and the read is rejected; level becomes 1 and underflow_out is set.
  - Otherwise: both are accepted and level is unchanged.
- Error flags:
  - write_in & !wr_ok sets overflow_out; FIFO contents are unchanged.
  - read_in & !rd_ok sets underflow_out; pointers are unchanged.
  - Both flags stay set until clear_in or reset.
- clear_in has priority over read_in and write_in in the same cycle. On the next edge it sets both pointers to 0, clears both sticky flags, and sets data_read_out to 0. Memory contents are left undefined and are never read.
- Pointer wrap: after 2^PTR_WIDTH accepted operations, a pointer returns to 0 with no effect on level or flags.

## Timing
- Reset values (nrst_in low, asynchronous): level_out 0, empty_out 1, almost_empty_out 1, full_out 0, almost_full_out 0, overflow_out 0, underflow_out 0, data_read_out 0, both pointers 0.
- Flags and level_out update on the same edge that accepts an operation, so they are valid in the following cycle.
- Write-to-read latency:
  - Non-FWFT mode: 2 cycles. The word is written at edge k, empty_out drops after edge k, read_in is sampled at edge k+1, and data is valid after edge k+1.
  - FWFT mode: the word is visible on data_read_out after edge k.
- Reset asserted mid-operation: pointers and flags clear immediately. Any in-flight write is lost.
- Throughput: one write and one read per cycle, sustained.

## Configuration
- FIFO_SYNC_FWFT_EN undefined (standard mode):
  - data_read_out is a register loaded with mem[rptr] on each accepted read; it holds its value otherwise.
  - read_in is a request; data appears one cycle later.
- FIFO_SYNC_FWFT_EN defined (first-word-fall-through mode):
  - data_read_out = mem[rptr] combinationally while !empty_out, and 0 while empty.
  - read_in acts as an acknowledge (pop) of the word currently shown.
  - Flags, level, and error behaviour are identical in both modes.

## Test plan
- Reset, then write 0x01..0x10 on consecutive cycles (DEPTH 16) → full_out=1 after the 16th edge; almost_full_out=1 from level 14; level_out=16. A 17th write sets overflow_out and leaves contents unchanged.
- Drain the 16 entries → data 0x01..0x10 in order (1-cycle latency in standard mode, 0 in FWFT); empty_out=1 after the last read; almost_empty_out=1 from level 2. One extra read sets underflow_out.
- When full, assert read_in and write_in together with data 0xAA for 1 cycle → level stays 16, no overflow. 0xAA emerges after the 15 older words.
- When empty, assert read_in and write_in together with data 0x55 → level 1, underflow_out=1. The next read returns 0x55.
- Run 40 interleaved write/read pairs to force pointer wrap (more than 32 operations) → data order preserved and level never exceeds 1.
- Fill to level 5, set overflow_out, then pulse clear_in together with write_in → level 0, empty_out=1, overflow_out=0, and the write is ignored. Pull nrst_in low mid-burst → all outputs reach their reset values asynchronously.

Source files
------------

// File: rtl/fifo_sync_circular.sv
// fifo_sync_circular: single-clock circular FIFO with level, almost-full/empty
// thresholds, sticky overflow/underflow flags and a synchronous flush.
// Ports:
//   clk_in, nrst_in (async, active-low), clear_in (sync flush)
//   write_in, data_write_in -> push; read_in -> pop / acknowledge
//   data_read_out, full_out, empty_out, almost_full_out, almost_empty_out
//   level_out (0..DEPTH), overflow_out, underflow_out (sticky)
// Option: define FIFO_SYNC_FWFT_EN for first-word-fall-through reads;
//   otherwise data_read_out is a register loaded on each accepted read.
module fifo_sync_circular #(
  parameter int DEPTH        = 16,
  parameter int WIDTH        = 8,
  parameter int AFULL_LEVEL  = 14,
  parameter int AEMPTY_LEVEL = 2,
  localparam int AW          = $clog2(DEPTH),
  localparam int PTR_WIDTH   = AW + 1
) (
  input  logic                 clk_in,
  input  logic                 nrst_in,
  input  logic                 clear_in,
  input  logic                 write_in,
  input  logic [WIDTH-1:0]     data_write_in,
  input  logic                 read_in,
  output logic [WIDTH-1:0]     data_read_out,
  output logic                 full_out,
  output logic                 empty_out,
  output logic                 almost_full_out,
  output logic                 almost_empty_out,
  output logic [PTR_WIDTH-1:0] level_out,
  output logic                 overflow_out,
  output logic                 underflow_out
);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [PTR_WIDTH-1:0] wptr;
  logic [PTR_WIDTH-1:0] rptr;
  logic [PTR_WIDTH-1:0] level;
  logic [AW-1:0]        waddr;
  logic [AW-1:0]        raddr;
  logic                 wr_ok;
  logic                 rd_ok;
  logic                 ovf_q;
  logic                 udf_q;

  assign waddr = wptr[AW-1:0];
  assign raddr = rptr[AW-1:0];

  // Wrap bit makes full and empty distinguishable.
  assign level = wptr - rptr;

  assign level_out        = level;
  assign full_out         = (level == PTR_WIDTH'(DEPTH));
  assign empty_out        = (level == '0);
  assign almost_full_out  = (level >= PTR_WIDTH'(AFULL_LEVEL));
  assign almost_empty_out = (level <= PTR_WIDTH'(AEMPTY_LEVEL));
  assign overflow_out     = ovf_q;
  assign underflow_out    = udf_q;

  // Flush wins over both requests; a read frees the slot a full write needs.
  assign rd_ok = read_in & ~clear_in & ~empty_out;
  assign wr_ok = write_in & ~clear_in & (~full_out | rd_ok);

  always_ff @(posedge clk_in) begin
    if (wr_ok) begin
      mem[waddr] <= data_write_in;
    end
  end

  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      wptr <= '0;
      rptr <= '0;
    end else if (clear_in) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_ok) begin
        wptr <= wptr + 1'b1;
      end
      if (rd_ok) begin
        rptr <= rptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else if (clear_in) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (write_in && !wr_ok) begin
        ovf_q <= 1'b1;
      end
      if (read_in && !rd_ok) begin
        udf_q <= 1'b1;
      end
    end
  end

`ifdef FIFO_SYNC_FWFT_EN
  // Head word is shown directly; read_in only acknowledges it.
  assign data_read_out = empty_out ? '0 : mem[raddr];
`else
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      rdata_q <= '0;
    end else if (clear_in) begin
      rdata_q <= '0;
    end else if (rd_ok) begin
      rdata_q <= mem[raddr];
    end
  end

  assign data_read_out = rdata_q;
`endif

endmodule
